// File: rtl/box_cfg_sched.sv
// Frame-synchronous box configuration scheduler: two round-robin requesters fill a
// pending table that is copied to the active table on each rising edge of vs_i.
module box_cfg_sched #(
    parameter int  NUM_BOXES = 4,
    parameter int  CW        = 10,
    parameter int  H_VALID   = 640,
    parameter int  V_VALID   = 480,
    localparam int IW        = $clog2(NUM_BOXES),
    localparam int DW        = 1 + IW + 4 * CW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vs_i,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [DW-1:0]             req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [DW-1:0]             req1_data,
    output logic [NUM_BOXES-1:0]      act_en,
    output logic [NUM_BOXES*4*CW-1:0] act_box,
    output logic                      commit_o,
    output logic                      err_o,
    output logic [15:0]               frame_cnt,
    output logic                      o_dbg_state
);
    localparam int          BW    = 4 * CW;
    localparam logic [CW:0] H_LIM = (CW + 1)'(H_VALID);
    localparam logic [CW:0] V_LIM = (CW + 1)'(V_VALID);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_vs_q;
    logic                            r_prio;
    logic                            r_err;
    logic [15:0]                     r_frame_cnt;
    logic [NUM_BOXES-1:0]            r_pend_en;
    logic [NUM_BOXES-1:0][BW-1:0]    r_pend_box;
    logic [NUM_BOXES-1:0]            r_dirty;
    logic [NUM_BOXES-1:0]            r_act_en;
    logic [NUM_BOXES-1:0][BW-1:0]    r_act_box;

    logic            w_vs_rise;
    logic            w_in_accept;
    logic            w_commit_now;
    logic            w_open;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_fire;
    logic [DW-1:0]   w_word;
    logic            w_en;
    logic [IW-1:0]   w_idx;
    logic [BW-1:0]   w_coords;
    logic [CW-1:0]   w_x0;
    logic [CW-1:0]   w_y0;
    logic [CW-1:0]   w_x1;
    logic [CW-1:0]   w_y1;
    logic            w_box_ok;

    assign w_vs_rise = vs_i & ~r_vs_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_in_accept  = 1'b0;
        w_commit_now = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                w_in_accept = 1'b1;
                if (w_vs_rise) begin
                    w_state_nxt  = ST_COMMIT;
                    w_commit_now = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

    // Handshake: a word transfers on a cycle where reqN_valid and reqN_ready are both
    // high; ready is combinational from the valids, prio and vs_i, and the requester
    // must hold valid and data stable until it sees ready.
    assign w_grant0   = req0_valid & (~req1_valid | ~r_prio);
    assign w_grant1   = req1_valid & (~req0_valid | r_prio);
    assign w_open     = w_in_accept & ~w_vs_rise;
    assign req0_ready = w_grant0 & w_open;
    assign req1_ready = w_grant1 & w_open;
    assign w_fire     = req0_ready | req1_ready;

    assign w_word   = req1_ready ? req1_data : req0_data;
    assign w_en     = w_word[DW-1];
    assign w_idx    = w_word[DW-2 -: IW];
    assign w_coords = w_word[BW-1:0];
    assign w_x0     = w_coords[4*CW-1 -: CW];
    assign w_y0     = w_coords[3*CW-1 -: CW];
    assign w_x1     = w_coords[2*CW-1 -: CW];
    assign w_y1     = w_coords[CW-1:0];
    assign w_box_ok = (w_x0 <= w_x1) & (w_y0 <= w_y1) &
                      ({1'b0, w_x1} < H_LIM) & ({1'b0, w_y1} < V_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCEPT;
            r_vs_q  <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vs_q  <= vs_i;
            if (w_fire) begin
                r_prio <= req0_ready;
            end
        end
    end

    // Writes and commits never share a cycle because ready is low on vs_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_en  <= '0;
            r_pend_box <= '0;
            r_dirty    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_fire & w_en & ~w_box_ok;
            if (w_commit_now) begin
                r_dirty <= '0;
            end else if (w_fire & (~w_en | w_box_ok)) begin
                r_dirty[w_idx]   <= 1'b1;
                r_pend_en[w_idx] <= w_en;
                if (w_en) begin
                    r_pend_box[w_idx] <= w_coords;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_en    <= '0;
            r_act_box   <= '0;
            r_frame_cnt <= 16'd0;
        end else if (w_commit_now) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            for (int k = 0; k < NUM_BOXES; k++) begin
                if (r_dirty[k]) begin
                    r_act_en[k]  <= r_pend_en[k];
                    r_act_box[k] <= r_pend_box[k];
                end
            end
        end
    end

    assign act_en      = r_act_en;
    assign act_box     = r_act_box;
    assign commit_o    = (r_state == ST_COMMIT);
    assign err_o       = r_err;
    assign frame_cnt   = r_frame_cnt;
    assign o_dbg_state = r_state;

endmodule
